// File: rtl/decode_unit.sv
// Instruction decode stage with the 8x16 register file for the 16-bit core.
// Latency: decode is combinational (zero cycles); register writes land on the rising clk edge.
// Backpressure: none; the stage decodes whatever instruction is presented every cycle.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset (clears register file)
//   inst, pc                 - instruction word and its address
//   result_w, result         - write-back address (0 = no write) and data
//   is_eq..is_jump, alith    - control flags and ALU operation for later stages
//   rd_addr                  - write-back destination (0 = none)
//   rd_out, rs_out           - source register contents as selected by the opcode
//   source1, source2         - ALU operands
//   disp6_out, imm9_out      - raw immediate fields, passed through unconditionally

`timescale 1ns/1ps

// Register file: two asynchronous read ports, one synchronous write port.
// R0 is an ordinary storage location; address 0 on the write port means "no write".
module decode_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  rd_sel_i,
    input  logic [2:0]  rs_sel_i,
    input  logic [2:0]  wr_addr_i,
    input  logic [15:0] wr_data_i,
    output logic [15:0] rd_data_o,
    output logic [15:0] rs_data_o
);
    logic [15:0] reg_file [0:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                reg_file[i] <= 16'h0000;
            end
        end else if (wr_addr_i != 3'd0) begin
            reg_file[wr_addr_i] <= wr_data_i;
        end
    end

    // No bypass: a same-cycle write is only visible after the edge.
    assign rd_data_o = reg_file[rd_sel_i];
    assign rs_data_o = reg_file[rs_sel_i];
endmodule

module decode_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst,
    input  logic [15:0] pc,
    input  logic [2:0]  result_w,
    input  logic [15:0] result,
    output logic        is_eq,
    output logic        mem_w,
    output logic        pc_w,
    output logic        is_ldi,
    output logic        is_ld_st,
    output logic        is_jump,
    output logic [1:0]  alith,
    output logic [2:0]  rd_addr,
    output logic [15:0] rd_out,
    output logic [15:0] rs_out,
    output logic [15:0] source1,
    output logic [15:0] source2,
    output logic [5:0]  disp6_out,
    output logic [8:0]  imm9_out
);
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_SUBI = 4'b0110;
    localparam logic [3:0] OP_INCR = 4'b0111;
    localparam logic [3:0] OP_DECR = 4'b1000;
    localparam logic [3:0] OP_LDI  = 4'b1001;
    localparam logic [3:0] OP_LD   = 4'b1010;
    localparam logic [3:0] OP_ST   = 4'b1011;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_BGT  = 4'b1101;
    localparam logic [3:0] OP_JUMP = 4'b1110;

    logic [3:0]  op;
    logic [2:0]  rd_f;
    logic [2:0]  rs_f;
    logic [15:0] se6;
    logic [15:0] se9;
    logic [15:0] se12;
    logic [15:0] rd_val;
    logic [15:0] rs_val;

    assign op   = inst[15:12];
    assign rd_f = inst[11:9];
    assign rs_f = inst[8:6];
    assign se6  = {{10{inst[5]}}, inst[5:0]};
    assign se9  = {{7{inst[8]}},  inst[8:0]};
    assign se12 = {{4{inst[11]}}, inst[11:0]};

    decode_regfile regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_sel_i  (rd_f),
        .rs_sel_i  (rs_f),
        .wr_addr_i (result_w),
        .wr_data_i (result),
        .rd_data_o (rd_val),
        .rs_data_o (rs_val)
    );

    // Immediate fields are forwarded raw regardless of opcode.
    assign disp6_out = inst[5:0];
    assign imm9_out  = inst[8:0];

    always_comb begin
        is_eq    = 1'b0;
        mem_w    = 1'b0;
        pc_w     = 1'b0;
        is_ldi   = 1'b0;
        is_ld_st = 1'b0;
        is_jump  = 1'b0;
        alith    = 2'b00;
        rd_addr  = 3'd0;
        rd_out   = 16'h0000;
        rs_out   = 16'h0000;
        source1  = 16'h0000;
        source2  = 16'h0000;

        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                // Opcodes 1..4 map directly onto ALU codes 0..3.
                alith   = 2'(op - 4'd1);
                rd_addr = rd_f;
                rd_out  = rd_val;
                rs_out  = rs_val;
                source1 = rd_val;
                source2 = rs_val;
            end
            OP_ADDI, OP_SUBI, OP_LDI: begin
                alith   = (op == OP_SUBI) ? 2'b01 : 2'b00;
                is_ldi  = (op == OP_LDI);
                rd_addr = rd_f;
                rd_out  = rd_val;
                source1 = rd_val;
                source2 = se9;
            end
            OP_INCR, OP_DECR: begin
                alith   = (op == OP_DECR) ? 2'b01 : 2'b00;
                rd_addr = rd_f;
                rd_out  = rd_val;
                source1 = rd_val;
                source2 = 16'd1;
            end
            OP_LD, OP_ST: begin
                is_ld_st = 1'b1;
                mem_w    = (op == OP_ST);
                // Stores have no register destination.
                rd_addr  = (op == OP_LD) ? rd_f : 3'd0;
                rd_out   = rd_val;
                rs_out   = rs_val;
                source1  = rd_val;
                source2  = se6;
            end
            OP_BEQ, OP_BGT: begin
                is_eq   = (op == OP_BEQ);
                pc_w    = 1'b1;
                rd_out  = rd_val;
                rs_out  = rs_val;
                source1 = pc;
                source2 = se6;
            end
            OP_JUMP: begin
                is_jump = 1'b1;
                pc_w    = 1'b1;
                source1 = pc;
                source2 = se12;
            end
            default: begin
                // NOP and HALT: everything stays at the zero defaults.
            end
        endcase
    end
endmodule

// File: tb/tb_decode_unit.sv
// Self-checking bench for decode_unit: reference model plus expected-value queue.
// Stimulus applied 1ns after each rising edge; outputs compared on the falling edge.
// No flow control; one expectation is pushed and popped per checked cycle.

`timescale 1ns/1ps

module tb_decode_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] inst = 16'h0000;
    logic [15:0] pc = 16'h0000;
    logic [2:0]  result_w = 3'd0;
    logic [15:0] result = 16'h0000;
    logic        is_eq, mem_w, pc_w, is_ldi, is_ld_st, is_jump;
    logic [1:0]  alith;
    logic [2:0]  rd_addr;
    logic [15:0] rd_out, rs_out, source1, source2;
    logic [5:0]  disp6_out;
    logic [8:0]  imm9_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [89:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] m_reg [8];
    logic        pend_rst = 1'b1;
    logic [2:0]  pend_wa = 3'd0;
    logic [15:0] pend_wd = 16'h0000;

    always #5 clk = ~clk;

    decode_unit dut (
        .clk       (clk),
        .rst       (rst),
        .inst      (inst),
        .pc        (pc),
        .result_w  (result_w),
        .result    (result),
        .is_eq     (is_eq),
        .mem_w     (mem_w),
        .pc_w      (pc_w),
        .is_ldi    (is_ldi),
        .is_ld_st  (is_ld_st),
        .is_jump   (is_jump),
        .alith     (alith),
        .rd_addr   (rd_addr),
        .rd_out    (rd_out),
        .rs_out    (rs_out),
        .source1   (source1),
        .source2   (source2),
        .disp6_out (disp6_out),
        .imm9_out  (imm9_out)
    );

    logic [89:0] obs_vec;
    assign obs_vec = {is_eq, mem_w, pc_w, is_ldi, is_ld_st, is_jump, alith, rd_addr,
                      rd_out, rs_out, source1, source2, disp6_out, imm9_out};

    task automatic check_eq(input string tag, input logic [89:0] obs, input logic [89:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode, written from the opcode table.
    function automatic logic [89:0] model(input logic [15:0] i, input logic [15:0] p);
        logic        f_eq, f_mw, f_pcw, f_ldi, f_ldst, f_jmp;
        logic [1:0]  alu;
        logic [2:0]  dst;
        logic [15:0] vrd, vrs, s1, s2;
        logic [15:0] rdv, rsv, i6, i9, i12;
        rdv = m_reg[i[11:9]];
        rsv = m_reg[i[8:6]];
        i6  = 16'($signed(i[5:0]));
        i9  = 16'($signed(i[8:0]));
        i12 = 16'($signed(i[11:0]));
        {f_eq, f_mw, f_pcw, f_ldi, f_ldst, f_jmp} = 6'b0;
        alu = 2'b00; dst = 3'd0; vrd = 16'h0; vrs = 16'h0; s1 = 16'h0; s2 = 16'h0;
        case (i[15:12])
            4'h1: begin alu = 2'b00; dst = i[11:9]; vrd = rdv; vrs = rsv; s1 = rdv; s2 = rsv; end
            4'h2: begin alu = 2'b01; dst = i[11:9]; vrd = rdv; vrs = rsv; s1 = rdv; s2 = rsv; end
            4'h3: begin alu = 2'b10; dst = i[11:9]; vrd = rdv; vrs = rsv; s1 = rdv; s2 = rsv; end
            4'h4: begin alu = 2'b11; dst = i[11:9]; vrd = rdv; vrs = rsv; s1 = rdv; s2 = rsv; end
            4'h5: begin alu = 2'b00; dst = i[11:9]; vrd = rdv; s1 = rdv; s2 = i9; end
            4'h6: begin alu = 2'b01; dst = i[11:9]; vrd = rdv; s1 = rdv; s2 = i9; end
            4'h7: begin alu = 2'b00; dst = i[11:9]; vrd = rdv; s1 = rdv; s2 = 16'd1; end
            4'h8: begin alu = 2'b01; dst = i[11:9]; vrd = rdv; s1 = rdv; s2 = 16'd1; end
            4'h9: begin f_ldi = 1'b1; dst = i[11:9]; vrd = rdv; s1 = rdv; s2 = i9; end
            4'hA: begin f_ldst = 1'b1; dst = i[11:9]; vrd = rdv; vrs = rsv; s1 = rdv; s2 = i6; end
            4'hB: begin f_ldst = 1'b1; f_mw = 1'b1; vrd = rdv; vrs = rsv; s1 = rdv; s2 = i6; end
            4'hC: begin f_eq = 1'b1; f_pcw = 1'b1; vrd = rdv; vrs = rsv; s1 = p; s2 = i6; end
            4'hD: begin f_pcw = 1'b1; vrd = rdv; vrs = rsv; s1 = p; s2 = i6; end
            4'hE: begin f_jmp = 1'b1; f_pcw = 1'b1; s1 = p; s2 = i12; end
            default: ;
        endcase
        return {f_eq, f_mw, f_pcw, f_ldi, f_ldst, f_jmp, alu, dst,
                vrd, vrs, s1, s2, i[5:0], i[8:0]};
    endfunction

    // One cycle: commit the previous cycle's write into the model (it has just
    // hit the DUT at this edge), drive new inputs, and queue the expected outputs.
    task automatic step(input string tag, input logic [15:0] i, input logic [15:0] p,
                        input logic [2:0] wa, input logic [15:0] wd,
                        input logic r, input logic chk_en);
        exp_t e;
        @(posedge clk);
        #1;
        if (pend_rst) begin
            for (int k = 0; k < 8; k++) m_reg[k] = 16'h0000;
        end else if (pend_wa != 3'd0) begin
            m_reg[pend_wa] = pend_wd;
        end
        inst = i; pc = p; result_w = wa; result = wd; rst = r;
        pend_rst = r; pend_wa = wa; pend_wd = wd;
        if (chk_en) begin
            e.tag = tag;
            e.exp = model(i, p);
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq(e.tag, obs_vec, e.exp);
        end
    end

    logic [89:0] zero_vec;
    logic [15:0] nop_hi;

    initial begin
        for (int k = 0; k < 8; k++) m_reg[k] = 16'h0000;

        step("rst0", 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b1, 1'b0);
        step("rst1", 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b1, 1'b0);
        step("reset_read", 16'h1283, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1);

        for (int k = 1; k < 8; k++)
            step("fill", 16'h0000, 16'h0000, 3'(k), 16'(10 * k), 1'b0, 1'b0);

        step("add",    16'h1283, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("sub",    16'h2283, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("and",    16'h3283, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("or",     16'h4283, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("addi",   16'h5203, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("subi",   16'h6203, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("incr",   16'h7203, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("decr",   16'h8203, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("ldi",    16'h9203, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("addi_neg", 16'h53FF, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("ld",     16'hA283, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("st",     16'hB283, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("beq",    16'hC283, 16'h0040, 3'd0, 16'h0, 1'b0, 1'b1);
        step("bgt",    16'hD283, 16'h0040, 3'd0, 16'h0, 1'b0, 1'b1);
        step("jump",   16'hE003, 16'h0040, 3'd0, 16'h0, 1'b0, 1'b1);
        step("jump_neg", 16'hEFFF, 16'h1000, 3'd0, 16'h0, 1'b0, 1'b1);
        step("ld_neg", 16'hA2BF, 16'h0000, 3'd0, 16'h0, 1'b0, 1'b1);

        // NOP/HALT must be exactly zero, checked against a literal as well.
        zero_vec = '0;
        step("nop",  16'h0000, 16'h0040, 3'd0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("nop_zero", obs_vec, zero_vec);
        step("halt", 16'hF000, 16'h0040, 3'd0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("halt_zero", obs_vec, zero_vec);
        step("halt_fields", 16'hFFFF, 16'h0040, 3'd0, 16'h0, 1'b0, 1'b1);

        // Write R3: old value visible during the write cycle, new after the edge.
        step("wr3_old",  16'h16C0, 16'h0000, 3'd3, 16'h1234, 1'b0, 1'b1);
        step("wr3_new",  16'h16C0, 16'h0000, 3'd0, 16'hBEEF, 1'b0, 1'b1);
        step("wr0_none", 16'h16C0, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1);
        step("r0_read",  16'h1000, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        check_eq("r3_literal", {74'd0, rd_out}, {74'd0, 16'h0000});
        step("r3_lit_setup", 16'h16C0, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("r3_literal2", {74'd0, rd_out}, {74'd0, 16'h1234});

        for (int k = 0; k < 24; k++)
            step("rand", 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                 16'($urandom), 1'b0, 1'b1);

        // One-cycle reset pulse, then every register must read back zero.
        step("rst_pulse", 16'h16C0, 16'h0000, 3'd5, 16'h5555, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            nop_hi = {4'h1, 3'(k), 3'((k + 1) % 8), 6'd0};
            step("post_rst", nop_hi, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1);
        end

        step("drain", 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("sb_drain", 90'(sb_q.size()), 90'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_unit.md
# decode_unit

Instruction decode stage of the 16-bit processor, containing the 8×16-bit register file. It splits a 16-bit instruction into opcode and fields, reads the source registers and produces the control flags used by the execute, memory and branch logic. It also produces the two ALU operands. Write-back from the later stage enters through `result_w`/`result`.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high; clears the register file.
- `inst`  in  16  instruction. Fields: op=[15:12], rd=[11:9], rs=[8:6], disp6=[5:0], imm9=[8:0], off12=[11:0].
- `pc`  in  16  address of `inst`.
- `result_w`  in  3  write-back register address; 0 means no write.
- `result`  in  16  write-back data.
- `is_eq`  out  1  branch-if-equal.
- `mem_w`  out  1  memory write (store).
- `pc_w`  out  1  PC may be overwritten (branch or jump).
- `is_ldi`  out  1  load-immediate.
- `is_ld_st`  out  1  memory access (load or store).
- `is_jump`  out  1  unconditional jump.
- `alith`  out  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
- `rd_addr`  out  3  destination register for write-back; 0 means none.
- `rd_out`  out  16  R[rd].
- `rs_out`  out  16  R[rs].
- `source1`  out  16  ALU operand A.
- `source2`  out  16  ALU operand B.
- `disp6_out`  out  6  raw inst[5:0], always.
- `imm9_out`  out  9  raw inst[8:0], always.

## Operation
- The register file is an internal array `reg_file[0:7]` of 16-bit words, in instance `regfile`.
- Reads are asynchronous on rd and rs.
- R0 reads as stored. Writes with `result_w`=0 are ignored.
- Sign extension: SE9 = inst[8:0] sign-extended to 16 bits, SE6 = inst[5:0] sign-extended, SE12 = inst[11:0] sign-extended.
- All outputs not listed for an opcode are 0. `disp6_out` and `imm9_out` are never zeroed.
- 0001 ADD, 0010 SUB, 0011 AND, 0100 OR:
  - `alith` = 00/01/10/11 respectively.
  - rd_addr=rd, rd_out=R[rd], rs_out=R[rs], source1=R[rd], source2=R[rs].
- 0101 ADDI (alith 00), 0110 SUBI (alith 01):
  - rd_addr=rd, rd_out=R[rd], rs_out=0, source1=R[rd], source2=SE9.
- 0111 INCR (alith 00), 1000 DECR (alith 01):
  - rd_addr=rd, rd_out=R[rd], rs_out=0, source1=R[rd], source2=16'd1.
- 1001 LDI:
  - is_ldi=1, alith 00, rd_addr=rd, rd_out=R[rd], rs_out=0, source1=R[rd], source2=SE9.
- 1010 LD:
  - is_ld_st=1, rd_addr=rd, rd_out=R[rd], rs_out=R[rs], source1=R[rd], source2=SE6.
- 1011 ST:
  - is_ld_st=1, mem_w=1, rd_addr=0, rd_out=R[rd], rs_out=R[rs], source1=R[rd], source2=SE6.
- 1100 BEQ:
  - is_eq=1, pc_w=1, rd_addr=0, rd_out=R[rd], rs_out=R[rs], source1=pc, source2=SE6.
- 1101 BGT:
  - pc_w=1, is_eq=0; other outputs as BEQ.
- 1110 JUMP:
  - is_jump=1, pc_w=1, rd_addr=0, rd_out=0, rs_out=0, source1=pc, source2=SE12.
- 0000 NOP, 1111 HALT:
  - All flags, rd_addr, rd_out, rs_out, source1 and source2 are 0.
  - No output may be X or Z.

## Timing
- Decode is purely combinational from `inst`, `pc` and register contents; zero-cycle latency.
- Register write occurs on the rising `clk` edge when `rst`=0 and `result_w`≠0: reg_file[result_w] ← result.
- There is no write-to-read bypass. A read in the same cycle as a write to the same register returns the old value; the new value is visible after the edge.
- While `rst`=1, every rising edge clears all eight registers to 0 and suppresses writes.
- After reset, every register-derived output is 0. Flags still follow `inst`.
- Reset may be asserted at any time. It takes effect at the next edge; the decode outputs carry no other state.

## Test plan
- Reset, then write R_i = 10·i via `result_w`/`result` over seven cycles.
  - Apply ADD 0001_001_010_000011: alith 00, rd_addr 1, rd_out 10, rs_out 20, source1 10, source2 20, disp6_out 3, imm9_out 0x083, all flags 0.
  - Repeat with SUB/AND/OR: alith 01/10/11.
- ADDI 0101_001_000000011: source1 10, source2 3, rs_out 0, imm9_out 3.
  - INCR 0111_001_000000011: source2 1.
  - DECR 1000_001_000000011: alith 01, source2 1.
  - LDI 1001_001_000000011: is_ldi 1, source2 3.
  - ADDI with imm9=0x1FF: source2 0xFFFF.
- LD 1010_001_010_000011: is_ld_st 1, rd_addr 1, source1 10, source2 3.
  - ST 1011_001_010_000011: mem_w 1, is_ld_st 1, rd_addr 0, rd_out 10, rs_out 20.
- With pc=0x0040:
  - BEQ 1100_001_010_000011: is_eq 1, pc_w 1, source1 0x0040, source2 3, rd_out 10, rs_out 20.
  - BGT 1101_001_010_000011: same with is_eq 0.
  - JUMP 0xE003: is_jump 1, pc_w 1, source1 0x0040, source2 3, rd_out 0.
- NOP 0x0000 and HALT 0xF000: every output exactly 0 (4-state compare).
- Write R3 with `result_w`=3, `result`=0x1234: rd_out for rd=3 is the old value before the edge and 0x1234 after.
  - A write with `result_w`=0 changes nothing.
  - Asserting `rst` for one cycle zeroes all registers.
